// File: rtl/key_event_pkg.sv
// Shared definitions for the key_event block: FSM state encoding, default timing
// constants and the timer width helper.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2,
        ST_WAIT2 = 2'd3
    } key_state_e;

    localparam int DEF_LONG_CYC   = 100_000_000;
    localparam int DEF_REPEAT_CYC = 20_000_000;
    localparam int DEF_DCLICK_CYC = 30_000_000;

    function automatic int timer_width(input int long_cyc, input int dclick_cyc);
        int m;
        m = (long_cyc > dclick_cyc) ? long_cyc : dclick_cyc;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/event_timer.sv
// Cycle counter for key_event: synchronous clear, count enable and terminal-count
// flags for the long-press, auto-repeat and double-click intervals.
module event_timer #(
    parameter int W          = 8,
    parameter int LONG_CYC   = 20,
    parameter int REPEAT_CYC = 5,
    parameter int DCLICK_CYC = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic at_long,
    output logic at_repeat,
    output logic at_dclick
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // The FSM clears on every terminal hit, so the count never wraps on its own.
    assign at_long   = (count == W'(LONG_CYC - 1));
    assign at_repeat = (count == W'(REPEAT_CYC - 1));
    assign at_dclick = (count == W'(DCLICK_CYC - 1));

endmodule

// File: rtl/key_event.sv
// Key event decoder: turns a debounced key level into press, release, long-press,
// auto-repeat and double-click pulses, all registered.
module key_event
    import key_event_pkg::*;
#(
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC,
    parameter int DCLICK_CYC = DEF_DCLICK_CYC
) (
    input  logic clk,
    input  logic rstn,
    input  logic button_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic dclick_pulse,
    output logic held
);

    localparam int TW = timer_width(LONG_CYC, DCLICK_CYC);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHORT = ST_SHORT;
    localparam logic [1:0] S_LONG  = ST_LONG;
    localparam logic [1:0] S_WAIT2 = ST_WAIT2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       btn_q;
    logic       rise;
    logic       fall;
    logic       dc_done;
    logic       dc_done_nxt;
    logic       clr;
    logic       en;
    logic       at_long;
    logic       at_repeat;
    logic       at_dclick;
    logic       press_nxt;
    logic       release_nxt;
    logic       long_nxt;
    logic       repeat_nxt;
    logic       dclick_nxt;

    assign rise = button_in & ~btn_q;
    assign fall = ~button_in & btn_q;
    assign held = btn_q;

    event_timer #(
        .W          (TW),
        .LONG_CYC   (LONG_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .DCLICK_CYC (DCLICK_CYC)
    ) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .en        (en),
        .at_long   (at_long),
        .at_repeat (at_repeat),
        .at_dclick (at_dclick)
    );

    always_comb begin
        state_nxt   = state;
        dc_done_nxt = dc_done;
        clr         = 1'b0;
        en          = 1'b0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        dclick_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                clr = 1'b1;
                if (rise) begin
                    press_nxt   = 1'b1;
                    dc_done_nxt = 1'b0;
                    state_nxt   = S_SHORT;
                end
            end
            S_SHORT: begin
                // dc_done marks a press that was itself a double click: no new window.
                if (fall) begin
                    release_nxt = 1'b1;
                    clr         = 1'b1;
                    state_nxt   = dc_done ? S_IDLE : S_WAIT2;
                end else if (button_in && at_long) begin
                    long_nxt  = 1'b1;
                    clr       = 1'b1;
                    state_nxt = S_LONG;
                end else begin
                    en = 1'b1;
                end
            end
            S_LONG: begin
                if (fall) begin
                    release_nxt = 1'b1;
                    clr         = 1'b1;
                    state_nxt   = S_IDLE;
                end else if (at_repeat) begin
                    repeat_nxt = 1'b1;
                    clr        = 1'b1;
                end else begin
                    en = 1'b1;
                end
            end
            S_WAIT2: begin
                // A rise in the expiry cycle still wins over the timeout.
                if (rise) begin
                    press_nxt   = 1'b1;
                    dclick_nxt  = 1'b1;
                    dc_done_nxt = 1'b1;
                    clr         = 1'b1;
                    state_nxt   = S_SHORT;
                end else if (at_dclick) begin
                    clr       = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    en = 1'b1;
                end
            end
            default: begin
                clr       = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            btn_q         <= 1'b0;
            dc_done       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            dclick_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            btn_q         <= button_in;
            dc_done       <= dc_done_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            dclick_pulse  <= dclick_nxt;
        end
    end

endmodule
